dmem_dump: RTL and testbench
============================

Name: dmem_dump

Overview:
- Readback unit for the data memory. The testbench preloads data memory as flat byte images; this block is the opposite direction and streams the data memory contents back out.
- On a start pulse it walks every word of data memory through a 1-cycle-latency read port. It emits each word as 4 bytes, least significant byte first, on a valid/ready byte stream.
- It sits beside proc's data memory and is used after a run to dump final memory state for comparison against golden images.

Parameters:
- DMEM_SIZE_BYTES, 32, data memory size in bytes; must be a multiple of 4 and at least 4.
- N_WORDS, DMEM_SIZE_BYTES/4, number of 32-bit words dumped (derived; not overridden).
- ADDR_W, $clog2(N_WORDS) with a minimum of 1, width of the word address.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  single-cycle request to begin a dump; ignored unless in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the final byte has been accepted.
- rd_en  out  1  data memory read enable.
- rd_addr  out  ADDR_W  word address of the read.
- rd_data  in  32  read data; valid in the cycle after the clock edge that samples rd_en=1.
- out_valid  out  1  byte available on out_data.
- out_ready  in  1  consumer accepts the byte when out_valid and out_ready are both 1 at a rising edge.
- out_data  out  8  current byte.
- out_last  out  1  high with out_valid on byte 4*N_WORDS-1 only.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; word_idx=0; byte_idx=0; word_buf=0.
  - All outputs 0: busy, done, rd_en, rd_addr, out_valid, out_data, out_last.
- State machine:
  - IDLE: start=1 → REQ, with word_idx=0 and byte_idx=0.
  - REQ (one cycle):
    - rd_en=1 and rd_addr=word_idx, driven from state.
    - Go to CAPT.
  - CAPT (one cycle): word_buf<=rd_data, then go to SEND.
  - SEND:
    - out_valid=1; out_data=word_buf[8*byte_idx+7 : 8*byte_idx].
    - out_last = (word_idx==N_WORDS-1) && (byte_idx==3).
    - On a handshake with byte_idx<3: byte_idx++.
    - On a handshake with byte_idx==3:
      - If it is not the last word: byte_idx=0, word_idx++, go to REQ.
      - If it is the last word: go to DONE.
    - Without a handshake: hold state. out_data and out_last are held stable.
  - DONE (one cycle): done=1, busy=1, then go to IDLE.
- Latency and throughput:
  - start sampled at edge 0 → REQ in cycle 1 → CAPT in cycle 2 → first out_valid in cycle 3.
  - Each word costs 2 overhead cycles plus 4 handshake cycles.
  - With out_ready held at 1, the total from start to done is 6*N_WORDS+1 cycles.
- rd_en is 0 outside REQ, and rd_addr then holds its last value. Exactly one read is issued per word, and the word is never re-read under backpressure.
- out_valid never drops before its handshake. No byte is skipped or duplicated.
- Outside SEND: out_valid=0, out_last=0, and out_data holds its last value.
- start while busy has no effect and is not queued.
- start in the DONE cycle is ignored.
- Reset mid-dump aborts immediately to IDLE. The next start re-dumps from word 0.
- N_WORDS=1: word_idx stays at 0. out_last appears on the 4th byte.
- word_idx never wraps. The final-word compare happens before the increment.

Test Plan:
- Memory model with 8 words 0x03020100, 0x07060504, …, 0x1F1E1D1C; out_ready=1; pulse start → bytes 0x00..0x1F in order, out_last only on 0x1F, done pulse exactly 49 cycles after start, exactly 8 rd_en pulses at addresses 0..7.
- Same memory; out_ready random with 50% low → same 32-byte sequence; out_data and out_last stable while out_valid=1 and out_ready=0; still exactly 8 reads.
- start pulsed again in cycles 5 and 20 of a dump → no restart, 32 bytes total, a single done pulse; busy=0 afterwards.
- reset_n dropped during word 3 byte 2 → all outputs 0 asynchronously; after release, start → full dump starting at 0x00.
- DMEM_SIZE_BYTES=4 with the word 0xDEADBEEF → bytes 0xEF, 0xBE, 0xAD, 0xDE; out_last on 0xDE; done 7 cycles after start.
- out_ready=0 for 100 cycles at the first byte → out_valid=1 and out_data=0x00 held throughout; no extra rd_en; dump completes normally once out_ready rises.

Source files
------------

// File: rtl/dmem_dump.sv
// dmem_dump: streams the whole data memory back out as a byte stream.
//
// On a start pulse the block walks every 32-bit word of data memory through
// a read port with one cycle of latency and emits each word as four bytes,
// least significant byte first, on a valid/ready stream. Used after a run to
// dump final memory contents for comparison against golden images.
//
// Ports:
//   clk        core clock, rising edge
//   reset_n    asynchronous, active-low reset
//   start      single-cycle dump request (ignored unless idle)
//   busy       high whenever the block is not idle
//   done       one-cycle pulse after the final byte is accepted
//   rd_en      data memory read enable
//   rd_addr    data memory word address
//   rd_data    read data, valid the cycle after rd_en is sampled
//   out_valid  byte available on out_data
//   out_ready  consumer accepts the byte on valid & ready
//   out_data   current byte
//   out_last   marks the final byte of the dump
module dmem_dump #(
    parameter  int DMEM_SIZE_BYTES = 32,
    localparam int N_WORDS         = DMEM_SIZE_BYTES / 4,
    localparam int ADDR_W          = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CAPT,
        S_SEND,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_idx;
    logic [31:0]       word_buf;

    logic              is_last_word;
    logic [1:0]        next_byte;

    // The final-word compare uses the current index, before any increment,
    // so word_idx never has to wrap.
    assign is_last_word = (word_idx == ADDR_W'(N_WORDS - 1));
    assign next_byte    = byte_idx + 2'd1;

    // All outputs are registered and updated alongside the state transition,
    // so out_data and rd_addr simply keep their last value when not written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            word_idx  <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // right-hand side below sees the pre-edge values.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_REQ;
                        word_idx <= '0;
                        byte_idx <= '0;
                        busy     <= 1'b1;
                        rd_en    <= 1'b1;
                        rd_addr  <= '0;
                    end
                end

                S_REQ: begin
                    // The read is in flight; data lands during CAPT.
                    state <= S_CAPT;
                    rd_en <= 1'b0;
                end

                S_CAPT: begin
                    state     <= S_SEND;
                    word_buf  <= rd_data;
                    out_valid <= 1'b1;
                    out_data  <= rd_data[7:0];
                    out_last  <= 1'b0;
                end

                S_SEND: begin
                    // Without a handshake nothing changes, so the byte on
                    // the stream stays stable under backpressure.
                    if (out_ready) begin
                        if (byte_idx != 2'd3) begin
                            byte_idx <= next_byte;
                            out_data <= word_buf[{next_byte, 3'b000} +: 8];
                            out_last <= is_last_word && (byte_idx == 2'd2);
                        end else begin
                            byte_idx  <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (is_last_word) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state    <= S_REQ;
                                word_idx <= word_idx + ADDR_W'(1);
                                rd_en    <= 1'b1;
                                rd_addr  <= word_idx + ADDR_W'(1);
                            end
                        end
                    end
                end

                S_DONE: begin
                    // start is deliberately not looked at here.
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    rd_en     <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_dump.sv
// Self-checking bench for dmem_dump: an 8-word instance driven from a table
// of dump scenarios with a byte scoreboard, plus hand-written sequences for
// mid-dump reset, a long stall and a 1-word instance.
module tb_dmem_dump;

    logic clk;
    logic reset_n;

    // 8-word instance
    logic        start;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;

    // 1-word instance
    logic        start1;
    logic        busy1;
    logic        done1;
    logic        rd_en1;
    logic [0:0]  rd_addr1;
    logic [31:0] rd_data1;
    logic        out_valid1;
    logic        out_ready1;
    logic [7:0]  out_data1;
    logic        out_last1;

    int total = 0;
    int bad   = 0;

    dmem_dump #(.DMEM_SIZE_BYTES(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last)
    );

    dmem_dump #(.DMEM_SIZE_BYTES(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .busy(busy1), .done(done1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_last(out_last1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: word i holds bytes 4i..4i+3, LSB first.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= {8'(4 * rd_addr + 3), 8'(4 * rd_addr + 2),
                        8'(4 * rd_addr + 1), 8'(4 * rd_addr)};
        end
        if (rd_en1) begin
            rd_data1 <= (rd_addr1 == 1'b0) ? 32'hDEADBEEF : 32'h0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard of expected bytes for the 8-word instance.
    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   pops;
    int   reads;
    int   exp_addr;
    int   done_cnt;

    logic       hold;
    logic [7:0] hold_data;
    logic       hold_last;

    task automatic push_dump();
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back('{data: 8'(i), last: (i == 31)});
        end
        pops     = 0;
        reads    = 0;
        exp_addr = 0;
        done_cnt = 0;
    endtask

    // Monitor at the falling edge: inputs were driven just after the rising
    // edge, so valid & ready here is exactly the handshake of the next edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(hold_data));
                check("hold_last", 32'(out_last), 32'(hold_last));
            end
            if (rd_en) begin
                reads++;
                check("rd_addr", 32'(rd_addr), 32'(exp_addr));
                exp_addr++;
            end
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_extra_byte: got %h expected no byte", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    pops++;
                    check("byte_data", 32'(out_data), 32'(e.data));
                    check("byte_last", 32'(out_last), 32'(e.last));
                end
            end
            hold      = out_valid && !out_ready;
            hold_data = out_data;
            hold_last = out_last;
        end
    end

    // Table of dump scenarios for the 8-word instance.
    typedef struct {
        int pct_low;   // percentage of cycles with out_ready low
        int start_a;   // cycle with an extra start pulse (0 = none)
        int start_b;
        int exp_done;  // expected start-to-done latency (0 = not checked)
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_dump(input int v, input int done_at);
        string p;
        p = $sformatf("v%0d_", v);
        check({p, "done_seen"}, 32'(done_at != 0), 32'd1);
        out_ready = 1'b1;
        start     = 1'b0;
        repeat (4) tick();
        check({p, "bytes"}, 32'(pops), 32'd32);
        check({p, "sb_empty"}, 32'(exp_q.size()), 32'd0);
        check({p, "reads"}, 32'(reads), 32'd8);
        check({p, "done_pulses"}, 32'(done_cnt), 32'd1);
        check({p, "busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic run_vec(input int v);
        int cyc;
        int done_at;
        push_dump();
        start = 1'b1;
        tick();             // edge 0 sampled start; now in cycle 1
        start   = 1'b0;
        cyc     = 1;
        done_at = 0;
        while (done_at == 0 && cyc < 2000) begin
            if (done) done_at = cyc;
            out_ready = ($urandom_range(0, 99) >= 32'(vecs[v].pct_low));
            start     = (cyc == vecs[v].start_a) || (cyc == vecs[v].start_b);
            tick();
            cyc++;
        end
        if (vecs[v].exp_done != 0)
            check($sformatf("v%0d_done_latency", v), 32'(done_at), 32'(vecs[v].exp_done));
        finish_dump(v, done_at);
    endtask

    initial begin
        int cyc;
        int done_at;
        logic [7:0] b1 [4];

        vecs[0] = '{pct_low: 0,  start_a: 0,  start_b: 0,  exp_done: 49};
        vecs[1] = '{pct_low: 50, start_a: 0,  start_b: 0,  exp_done: 0};
        vecs[2] = '{pct_low: 0,  start_a: 5,  start_b: 20, exp_done: 49};
        vecs[3] = '{pct_low: 0,  start_a: 49, start_b: 0,  exp_done: 49};

        reset_n    = 1'b0;
        start      = 1'b0;
        out_ready  = 1'b0;
        start1     = 1'b0;
        out_ready1 = 1'b1;
        push_dump();
        exp_q.delete();

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        reset_n = 1'b1;
        tick();

        for (int v = 0; v < 4; v++) begin
            run_vec(v);
        end

        // Reset during word 3 byte 2 (cycle 23), then a fresh full dump.
        push_dump();
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (22) tick();  // now in cycle 23
        check("pre_rst_byte", 32'(out_data), 32'h0E);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rd_en", 32'(rd_en), 32'd0);
        check("arst_rd_addr", 32'(rd_addr), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_out_last", 32'(out_last), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        exp_q.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        run_vec(0);

        // Stall 100 cycles on the first byte.
        push_dump();
        out_ready = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();   // cycle 3: first byte presented
        for (int i = 0; i < 100; i++) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'h00);
            tick();
        end
        check("stall_reads", 32'(reads), 32'd1);
        out_ready = 1'b1;
        done_at   = 0;
        cyc       = 0;
        while (done_at == 0 && cyc < 200) begin
            if (done) done_at = cyc + 1;
            tick();
            cyc++;
        end
        finish_dump(9, done_at);

        // 1-word instance holding 0xDEADBEEF.
        b1[0] = 8'hEF;
        b1[1] = 8'hBE;
        b1[2] = 8'hAD;
        b1[3] = 8'hDE;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 1) check("w1_rd_en", 32'(rd_en1), 32'd1);
            if (c >= 3 && c <= 6) begin
                check($sformatf("w1_valid_c%0d", c), 32'(out_valid1), 32'd1);
                check($sformatf("w1_data_c%0d", c), 32'(out_data1), 32'(b1[c-3]));
                check($sformatf("w1_last_c%0d", c), 32'(out_last1), 32'(c == 6));
            end
            check($sformatf("w1_done_c%0d", c), 32'(done1), 32'(c == 7));
            tick();
        end
        check("w1_busy_after", 32'(busy1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
